icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
Direct-mapped, read-only instruction cache sitting between the fetch stage and the memory controller. Serves the datapath's instruction requests (imemREN/imemaddr → ihit/imemload) from a one-word-per-frame array. On a miss it fetches the word from memory with a single-outstanding-request handshake, fills the frame, and serves the hit on a later cycle. Fetch holds its PC while ihit is low.

Parameters:
IDX_W, 4, index width; frame count = 2**IDX_W (16 frames)
TAG_W, 26, tag width; must equal 32 - IDX_W - 2

Ports:
CLK  in  1  clock, all state on rising edge
nRST  in  1  reset, synchronous, active-high (nRST=1 at a rising edge resets)
imemREN  in  1  datapath instruction read request
imemaddr  in  32  datapath instruction byte address
ihit  out  1  requested word valid on imemload this cycle
imemload  out  32  instruction word
iREN  out  1  memory read request
iaddr  out  32  memory word address, bits [1:0] always 0
iwait  in  1  memory busy; iwait=0 while iREN=1 means iload valid this cycle
iload  in  32  memory read data

Behaviour:
- Address split: tag = addr[31:IDX_W+2], idx = addr[IDX_W+1:2], addr[1:0] ignored.
- Storage per frame: valid bit, TAG_W tag, 32-bit data.
- FSM states: IDLE, FETCH.
- IDLE:
  - Hit when imemREN=1, valid[idx]=1 and tag[idx]==tag. Then ihit=1 and imemload=data[idx] combinationally in the same cycle, with no memory traffic.
  - Miss when imemREN=1 and there is no hit. Latch {imemaddr[31:2],2'b00} into miss_addr and go to FETCH next cycle. ihit=0.
  - imemREN=0: ihit=0, stay IDLE.
- FETCH:
  - iREN=1, iaddr=miss_addr, ihit=0 regardless of imemaddr.
  - When iwait=0: write iload, miss_addr tag and valid=1 into frame miss_addr idx; return to IDLE.
  - No forwarding: the hit is presented in the following IDLE cycle if imemaddr still matches.
  - Miss latency = 1 (detect) + memory wait cycles + 1 (hit cycle).
- Request withdrawn or changed during FETCH: the fill still completes to miss_addr. IDLE then re-evaluates the current imemaddr.
- Conflict: a fill to an occupied idx overwrites tag/data unconditionally.
- Outputs outside a hit: imemload=0 whenever ihit=0. iREN=0 and iaddr=0 in IDLE.
- Reset (nRST=1 at edge):
  - All valid bits cleared, FSM to IDLE, miss_addr=0.
  - Outputs after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
  - Reset during FETCH aborts the fill: no frame is written, and iREN is 0 from the cycle after the reset edge.
- Data/tag arrays need no reset; only valid bits are reset.
- Exactly one outstanding memory request at any time. iREN never drops before iwait=0 except on reset.

Optional Feature:
ICACHE_STATS_EN:
- Defined: adds outputs hit_count (32) and miss_count (32).
  - hit_count increments on each cycle with ihit=1.
  - miss_count increments on each IDLE→FETCH transition.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss: reset, imemREN=1, imemaddr=0x00000040, memory returns 0x8C220004 after 3 iwait cycles.
  → iREN=1 with iaddr=0x40 for 4 cycles; ihit=1 with imemload=0x8C220004 exactly one cycle after iwait falls.
- Hit after fill: re-request 0x40, then 0x42.
  → ihit=1 same cycle with 0x8C220004 for both; iREN stays 0.
- Conflict miss: fill 0x40, then request 0x440 (same idx 0, different tag), then 0x40 again.
  → two further misses; iaddr=0x440 then 0x40; final imemload equals the 0x40 data.
- Request change mid-fetch: miss on 0x80, switch imemaddr to 0x84 during FETCH.
  → iaddr stays 0x80 until fill; then a new miss for 0x84; a later 0x80 request hits.
- Reset mid-fetch: assert nRST during FETCH of 0x100, then request 0x100.
  → iREN=0 the cycle after reset; the new request misses (frame not filled).
- With ICACHE_STATS_EN: sequence cold miss 0x40 then 3 hit cycles.
  → miss_count=1, hit_count=3; both 0 after reset.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one word per frame and a single outstanding memory fill.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int FRAMES = 2 ** IDX_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [FRAMES-1:0]  valid_r;
    logic [TAG_W-1:0]   tag_r  [FRAMES];
    logic [31:0]        data_r [FRAMES];
    logic [31:0]        miss_addr_r;

    logic [TAG_W-1:0]   req_tag_s;
    logic [IDX_W-1:0]   req_idx_s;
    logic [IDX_W-1:0]   fill_idx_s;
    logic               lookup_hit_s;
    logic               miss_s;
    logic               fill_s;
    logic               unused_addr_s;

    assign req_tag_s     = imemaddr[31:IDX_W+2];
    assign req_idx_s     = imemaddr[IDX_W+1:2];
    assign fill_idx_s    = miss_addr_r[IDX_W+1:2];
    assign lookup_hit_s  = imemREN && valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    assign miss_s        = (state_r == IDLE) && imemREN && !lookup_hit_s;
    assign fill_s        = (state_r == FETCH) && !iwait;
    assign unused_addr_s = ^imemaddr[1:0];

    // FSM state register
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = miss_s ? FETCH : IDLE;
            FETCH:   next_state_s = iwait ? FETCH : IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs: hits are served combinationally, memory request held for the whole fetch
    always_comb begin
        ihit     = 1'b0;
        imemload = 32'd0;
        iREN     = 1'b0;
        iaddr    = 32'd0;
        case (state_r)
            IDLE: begin
                if (lookup_hit_s) begin
                    ihit     = 1'b1;
                    imemload = data_r[req_idx_s];
                end else begin
                    ihit     = 1'b0;
                    imemload = 32'd0;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr_r;
            end
            default: begin
                iREN  = 1'b0;
                iaddr = 32'd0;
            end
        endcase
    end

    // Miss address capture on the IDLE to FETCH transition
    always_ff @(posedge CLK) begin
        if (nRST) begin
            miss_addr_r <= 32'd0;
        end else if (miss_s) begin
            miss_addr_r <= {imemaddr[31:2], 2'b00};
        end
    end

    // Valid bits; a reset in the fill cycle wins so an aborted fill never becomes visible
    always_ff @(posedge CLK) begin
        if (nRST) begin
            valid_r <= '0;
        end else if (fill_s) begin
            valid_r[fill_idx_s] <= 1'b1;
        end
    end

    // Tag and data arrays, written only by a completed fill
    always_ff @(posedge CLK) begin
        if (!nRST && fill_s) begin
            tag_r[fill_idx_s]  <= miss_addr_r[31:IDX_W+2];
            data_r[fill_idx_s] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating hit counter
    always_ff @(posedge CLK) begin
        if (nRST) begin
            hit_count <= 32'd0;
        end else if (ihit && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
        end
    end

    // Saturating miss counter
    always_ff @(posedge CLK) begin
        if (nRST) begin
            miss_count <= 32'd0;
        end else if (miss_s && (miss_count != 32'hFFFF_FFFF)) begin
            miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus randomized traffic against a
// behavioural cache/memory model kept as plain arrays indexed by frame.
module tb_icache_direct;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: which word address each frame holds, plus backing memory contents
    bit          m_valid [16];
    logic [31:0] m_word  [16];
    logic [31:0] mem [logic [31:0]];
    int          m_hits;
    int          m_misses;

    icache_direct dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic mem_read(input logic [31:0] wa, output logic [31:0] d);
        if (!mem.exists(wa)) mem[wa] = $urandom;
        d = mem[wa];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic check_idle_quiet(input string name);
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'd0 || iREN !== 1'b0 || iaddr !== 32'd0) begin
            errors++;
            $display("FAIL %s: ihit=%b imemload=%h iREN=%b iaddr=%h, want 0/0/0/0",
                     name, ihit, imemload, iREN, iaddr);
        end
    endtask

    // One FETCH phase for word address wa: waits busy cycles, then the data cycle
    task automatic fetch_phase(input logic [31:0] wa, input int waits, input bit do_reset);
        logic [31:0] d;
        mem_read(wa, d);
        for (int i = 0; i <= waits; i++) begin
            iwait = (i < waits);
            iload = (i < waits) ? $urandom : d;
            if (i == waits && do_reset) nRST = 1'b1;
            #1;
            checks++;
            if (iREN !== 1'b1 || iaddr !== wa || ihit !== 1'b0 || imemload !== 32'd0) begin
                errors++;
                $display("FAIL fetch %h cyc %0d: iREN=%b iaddr=%h ihit=%b imemload=%h, want 1/%h/0/0",
                         wa, i, iREN, iaddr, ihit, imemload, wa);
            end
            if (i == waits && !do_reset) begin
                m_valid[wa[5:2]] = 1'b1;
                m_word[wa[5:2]]  = wa;
            end
            cyc();
        end
        iwait = 1'b1;
        if (do_reset) begin
            nRST = 1'b0;
            model_clear();
        end
    endtask

    // Issue a request; returns whether the model expected a miss (i.e. the first cycle)
    task automatic probe(input logic [31:0] a, output bit was_miss);
        logic [31:0] wa;
        logic [31:0] d;
        bit hit_exp;
        wa = {a[31:2], 2'b00};
        imemREN = 1'b1;
        imemaddr = a;
        iwait = 1'b1;
        #1;
        hit_exp = m_valid[a[5:2]] && (m_word[a[5:2]] == wa);
        checks++;
        if (ihit !== hit_exp) begin
            errors++;
            $display("FAIL lookup %h: ihit=%b want %b", a, ihit, hit_exp);
        end
        if (hit_exp) begin
            mem_read(wa, d);
            m_hits++;
            checks++;
            if (imemload !== d || iREN !== 1'b0) begin
                errors++;
                $display("FAIL hitdata %h: imemload=%h iREN=%b want %h/0", a, imemload, iREN, d);
            end
        end else begin
            m_misses++;
            checks++;
            if (imemload !== 32'd0 || iREN !== 1'b0) begin
                errors++;
                $display("FAIL misscyc %h: imemload=%h iREN=%b want 0/0", a, imemload, iREN);
            end
        end
        was_miss = !hit_exp;
        cyc();
    endtask

    // Complete access: miss detect, fill, then the hit cycle
    task automatic do_access(input logic [31:0] a, input int waits);
        bit was_miss;
        bit dummy;
        probe(a, was_miss);
        if (was_miss) begin
            fetch_phase({a[31:2], 2'b00}, waits, 1'b0);
            probe(a, dummy);
            checks++;
            if (dummy) begin
                errors++;
                $display("FAIL postfill %h: expected hit after fill, model saw miss", a);
            end
        end
    endtask

    task automatic expect_miss_then_fill(input logic [31:0] a, input int waits);
        bit was_miss;
        bit dummy;
        probe(a, was_miss);
        checks++;
        if (!was_miss) begin
            errors++;
            $display("FAIL expmiss %h: got hit 1, want miss", a);
            return;
        end
        fetch_phase({a[31:2], 2'b00}, waits, 1'b0);
        probe(a, dummy);
    endtask

    task automatic test_reset();
        nRST = 1'b1;
        imemREN = 1'b1;
        imemaddr = 32'h40;
        cyc();
        cyc();
        nRST = 1'b0;
        imemREN = 1'b0;
        model_clear();
        #1;
        check_idle_quiet("reset_outputs");
`ifdef ICACHE_STATS_EN
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: hit=%0d miss=%0d want 0/0", hit_count, miss_count);
        end
`endif
        cyc();
    endtask

    task automatic test_cold_miss();
        mem[32'h40] = 32'h8C22_0004;
        expect_miss_then_fill(32'h40, 3);
        checks++;
        if (m_word[0] !== 32'h40 || mem[32'h40] !== 32'h8C22_0004) begin
            errors++;
            $display("FAIL cold_model: frame0=%h", m_word[0]);
        end
    endtask

    task automatic test_hit_after_fill();
        do_access(32'h40, 0);
        do_access(32'h42, 0);
        imemREN = 1'b0;
        #1;
        check_idle_quiet("hit_then_idle");
        cyc();
    endtask

    task automatic test_conflict();
        expect_miss_then_fill(32'h440, 2);
        expect_miss_then_fill(32'h40, 1);
        imemREN = 1'b1;
        imemaddr = 32'h40;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h8C22_0004) begin
            errors++;
            $display("FAIL conflict_final: ihit=%b imemload=%h want 1/8c220004", ihit, imemload);
        end
        cyc();
    endtask

    task automatic test_change_mid_fetch();
        bit was_miss;
        probe(32'h80, was_miss);
        imemaddr = 32'h84;
        fetch_phase(32'h80, 2, 1'b0);
        expect_miss_then_fill(32'h84, 1);
        probe(32'h80, was_miss);
        checks++;
        if (was_miss) begin
            errors++;
            $display("FAIL change_refetch: 0x80 missed, want hit");
        end
        // Withdrawn request: fill still lands, IDLE then stays quiet
        probe(32'hC8, was_miss);
        imemREN = 1'b0;
        fetch_phase(32'hC8, 1, 1'b0);
        #1;
        check_idle_quiet("withdrawn_idle");
        cyc();
        do_access(32'hC8, 0);
    endtask

    task automatic test_reset_mid_fetch();
        bit was_miss;
        probe(32'h100, was_miss);
        fetch_phase(32'h100, 1, 1'b1);
        imemREN = 1'b0;
        #1;
        check_idle_quiet("after_reset_fetch");
        cyc();
        expect_miss_then_fill(32'h100, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                imemREN = 1'b0;
                imemaddr = $urandom;
                #1;
                check_idle_quiet("rand_idle");
                cyc();
            end else begin
                a = {$urandom_range(0, 2) << 6, 6'd0} | {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                do_access(a, $urandom_range(0, 3));
            end
        end
    endtask

    task automatic test_stats();
`ifdef ICACHE_STATS_EN
        checks++;
        if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_misses)) begin
            errors++;
            $display("FAIL stats_random: hit=%0d miss=%0d want %0d/%0d", hit_count, miss_count, m_hits, m_misses);
        end
        test_reset();
        do_access(32'h40, 3);
        do_access(32'h40, 0);
        do_access(32'h40, 0);
        imemREN = 1'b0;
        #1;
        checks++;
        if (hit_count !== 32'd3 || miss_count !== 32'd1) begin
            errors++;
            $display("FAIL stats_seq: hit=%0d miss=%0d want 3/1", hit_count, miss_count);
        end
        cyc();
        test_reset();
`endif
    endtask

    initial begin
        nRST = 1'b1;
        imemREN = 1'b0;
        imemaddr = 32'd0;
        iwait = 1'b1;
        iload = 32'd0;
        model_clear();
        cyc();
        test_reset();
        test_cold_miss();
        test_hit_after_fill();
        test_conflict();
        test_change_mid_fetch();
        test_reset_mid_fetch();
        test_random();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
